// File: rtl/bin_to_bcd_2digit.sv
// Sequential double-dabble converter: unsigned binary in, two BCD digits out.
// One shift/adjust iteration per clock behind a start/busy/done handshake.
// Results above 99 saturate to 9/9 with ovf set. Digit outputs are only
// written when a conversion finishes, so the display stage downstream can
// consume them directly without extra latching.
module bin_to_bcd_2digit #(
  parameter int IN_WIDTH = 7,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic [3:0]          tens,
  output logic [3:0]          ones,
  output logic                ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

  state_t              state;
  logic [7:0]          bcd;
  logic [IN_WIDTH-1:0] bin_sr;
  logic [CNT_W-1:0]    cnt;
  logic                sat;
  logic                in_gt99;
  logic [7:0]          bcd_next;

  // A BCD nibble of 5 or more would exceed 9 after doubling; pre-add 3
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // One double-dabble iteration on the 8-bit accumulator; the bit shifted
  // out of the tens nibble (hundreds) is dropped, saturation covers it
  function automatic logic [7:0] dabble_step(input logic [7:0] b, input logic msb);
    logic [7:0] adj;
    adj = {add3(b[7:4]), add3(b[3:0])};
    return {adj[6:0], msb};
  endfunction

  // Zero-extend before comparing so narrow inputs never saturate
  assign in_gt99  = (16'(bin_in) > 16'd99);
  assign bcd_next = dabble_step(bcd, bin_sr[IN_WIDTH-1]);

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      tens   <= 4'd0;
      ones   <= 4'd0;
      ovf    <= 1'b0;
      bcd    <= '0;
      bin_sr <= '0;
      cnt    <= '0;
      sat    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bin_sr <= bin_in;
            bcd    <= '0;
            cnt    <= '0;
            sat    <= in_gt99;
            busy   <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= bcd_next;
          bin_sr <= bin_sr << 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          if (sat) begin
            tens <= 4'd9;
            ones <= 4'd9;
            ovf  <= 1'b1;
          end else begin
            tens <= bcd[7:4];
            ones <= bcd[3:0];
            ovf  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_2digit.sv
// Testbench for bin_to_bcd_2digit: scoreboard of expected digits pushed at
// each accepted start, observed digits collected on every done pulse.
module tb_bin_to_bcd_2digit;

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       v;
  } res_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [6:0] bin_in;
  logic       busy;
  logic       done;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       ovf;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  // window statistics
  int   n_done;
  int   first_lat;
  int   busy_hi;
  int   unstable;
  int   period_err;
  logic acc_busy;

  bin_to_bcd_2digit #(.IN_WIDTH(7), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin_in(bin_in),
    .busy  (busy),
    .done  (done),
    .tens  (tens),
    .ones  (ones),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int v);
    res_t r;
    if (v > 99) begin
      r.t = 4'd9; r.o = 4'd9; r.v = 1'b1;
    end else begin
      r.t = 4'(v / 10); r.o = 4'(v % 10); r.v = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start and record the expected result
  task automatic start_conv(input int v);
    bin_in = 7'(v);
    start  = 1'b1;
    tick();
    acc_busy = busy;
    start    = 1'b0;
    bin_in   = 7'($urandom);
    exp_q.push_back(model(v));
  endtask

  // Run ncyc clocks, collecting done results and handshake statistics
  task automatic run_window(input int ncyc);
    res_t last;
    int   prev_i;
    last       = '{t: tens, o: ones, v: ovf};
    n_done     = 0;
    first_lat  = -1;
    busy_hi    = 0;
    unstable   = 0;
    period_err = 0;
    prev_i     = -1;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (busy) busy_hi++;
      if (done) begin
        n_done++;
        if (first_lat < 0) first_lat = i;
        if (prev_i >= 0 && (i - prev_i) != 9) period_err++;
        prev_i = i;
        last   = '{t: tens, o: ones, v: ovf};
        obs_q.push_back(last);
      end else if (last !== '{t: tens, o: ones, v: ovf}) begin
        unstable++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bin_in = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, ovf} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/ovf=%b required 000", {busy, done, ovf});
    end
    checks++;
    if ({tens, ones} !== 8'h00) begin
      errors++;
      $display("FAIL reset_digits: got %0d/%0d required 0/0", tens, ones);
    end
  endtask

  task automatic test_basic();
    res_t e, o;
    start_conv(42);
    run_window(10);
    checks++;
    if (first_lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: done after %0d clocks, required 8", first_lat);
    end
    checks++;
    if ((busy_hi + int'(acc_busy)) !== 8) begin
      errors++;
      $display("FAIL basic_busy_len: busy %0d cycles, required 8", busy_hi + int'(acc_busy));
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL basic_done_count: %0d pulses, required 1", n_done);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic_result: got %0d/%0d ovf=%0d required %0d/%0d ovf=%0d", o.t, o.o, o.v, e.t, e.o, e.v);
      end
    end
  endtask

  task automatic test_boundaries();
    res_t e, o;
    start_conv(0);
    run_window(10);
    start_conv(99);
    run_window(10);
    checks++;
    if (unstable !== 0) begin
      errors++;
      $display("FAIL hold_between_done: %0d cycles changed, required 0", unstable);
    end
    checks++;
    if (obs_q.size() !== 2) begin
      errors++;
      $display("FAIL boundary_count: %0d results, required 2", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL boundary_result: got %0d/%0d ovf=%0d required %0d/%0d ovf=%0d", o.t, o.o, o.v, e.t, e.o, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_saturate();
    res_t e, o;
    int   vals[3] = '{100, 127, 5};
    for (int k = 0; k < 3; k++) begin
      start_conv(vals[k]);
      run_window(10);
    end
    checks++;
    if (obs_q.size() !== 3) begin
      errors++;
      $display("FAIL sat_count: %0d results, required 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sat_result: got %0d/%0d ovf=%0d required %0d/%0d ovf=%0d", o.t, o.o, o.v, e.t, e.o, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ignore_start();
    res_t e, o;
    start_conv(37);
    tick(); tick();
    bin_in = 7'd81; start = 1'b1;
    tick();
    start = 1'b0;
    run_window(12);
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL ignore_done_count: %0d pulses, required 1", n_done);
    end
    checks++;
    if (first_lat !== 5) begin
      errors++;
      $display("FAIL ignore_latency: done at window clock %0d, required 5", first_lat);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ignore_result: got %0d/%0d ovf=%0d required %0d/%0d ovf=%0d", o.t, o.o, o.v, e.t, e.o, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_abort();
    res_t e, o;
    start_conv(64);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    checks++;
    if ({busy, done, tens, ones, ovf} !== 11'b0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b done=%b %0d/%0d ovf=%b required all 0", busy, done, tens, ones, ovf);
    end
    run_window(12);
    checks++;
    if (n_done !== 0 || busy_hi !== 0) begin
      errors++;
      $display("FAIL abort_no_done: done=%0d busy=%0d cycles, required 0/0", n_done, busy_hi);
    end
    obs_q.delete();
    start_conv(64);
    run_window(10);
    checks++;
    if (obs_q.size() !== 1) begin
      errors++;
      $display("FAIL abort_restart_count: %0d results, required 1", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_restart_result: got %0d/%0d ovf=%0d required %0d/%0d ovf=%0d", o.t, o.o, o.v, e.t, e.o, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    int   nd1;
    bin_in = 7'd58; start = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(model(58));
    run_window(30);
    nd1 = n_done;
    checks++;
    if (first_lat !== 9) begin
      errors++;
      $display("FAIL b2b_first_done: window clock %0d, required 9", first_lat);
    end
    checks++;
    if (period_err !== 0) begin
      errors++;
      $display("FAIL b2b_period: %0d bad spacings, required 0", period_err);
    end
    start = 1'b0;
    run_window(10);
    checks++;
    if ((nd1 + n_done) !== 4) begin
      errors++;
      $display("FAIL b2b_count: %0d pulses, required 4", nd1 + n_done);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_result: got %0d/%0d ovf=%0d required %0d/%0d ovf=%0d", o.t, o.o, o.v, e.t, e.o, e.v);
      end
    end
    exp_q.delete(); obs_q.delete();
    // reset and start on the same edge: reset must win
    reset = 1'b1; start = 1'b1; bin_in = 7'd58;
    tick();
    reset = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || {tens, ones} !== 8'h00) begin
      errors++;
      $display("FAIL reset_start_same_edge: busy=%b %0d/%0d required 0 0/0", busy, tens, ones);
    end
    run_window(12);
    checks++;
    if (n_done !== 0 || busy_hi !== 0) begin
      errors++;
      $display("FAIL reset_start_no_conv: done=%0d busy=%0d cycles, required 0/0", n_done, busy_hi);
    end
    obs_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; bin_in = '0; acc_busy = 1'b0;
    test_reset();
    test_basic();
    test_boundaries();
    test_saturate();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bin_to_bcd_2digit.md
Name: bin_to_bcd_2digit

Overview:
Sequential double-dabble converter that turns an unsigned binary value into two BCD digits (tens, ones) for the two-digit anode-cycling display stage. It sits directly upstream of the display multiplexer: its tens/ones outputs drive that stage's two 4-bit digit inputs. It uses a start/busy/done handshake. Values above 99 saturate to 99 and raise an overflow flag.

Parameters:
IN_WIDTH, 7, width of binary input; legal range 4..10.
CNT_W, 4, width of iteration counter; must satisfy 2^CNT_W > IN_WIDTH.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request conversion; sampled only in IDLE.
bin_in  input  IN_WIDTH  unsigned value; captured on the accepted start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when a new result is presented.
tens  output  4  BCD tens digit, 0..9; held between conversions.
ones  output  4  BCD ones digit, 0..9; held between conversions.
ovf  output  1  captured value was > 99; updated together with done.

Behaviour:
- Clock and reset:
  - One clock (clk).
  - reset is synchronous and active-high. It is sampled on the rising edge of clk and has priority over all other logic.
- Reset values:
  - State = IDLE; busy=0, done=0, tens=0, ones=0, ovf=0.
  - Internal shift register and iteration counter = 0.
- States:
  - IDLE:
    - busy=0.
    - If start=1 at edge E0: capture bin_in into the binary shift register, clear the 8-bit BCD accumulator, set counter=0, latch sat = (bin_in > 99), and go to SHIFT. busy=1 from E0.
    - If start=0: stay in IDLE; outputs hold.
  - SHIFT (one iteration per clock, IN_WIDTH iterations at edges E1..E_IN_WIDTH):
    - For each BCD nibble >= 5, add 3 (4-bit, no carry between nibbles).
    - Shift {bcd, bin} left by 1, taking the binary MSB into the BCD LSB.
    - counter += 1.
    - When counter == IN_WIDTH-1 on the current edge, go to FINISH.
  - FINISH (edge E_IN_WIDTH+1):
    - If sat=1: tens=9, ones=9, ovf=1. Otherwise tens=bcd[7:4], ones=bcd[3:0], ovf=0.
    - done=1 for exactly this one cycle; busy=0.
    - Next state IDLE.
- Latency:
  - done rises IN_WIDTH+1 clocks after the accepting edge (8 for the default).
  - busy is high for exactly IN_WIDTH+1 cycles.
  - Back-to-back throughput: a new start may be accepted on the edge after done falls.
- Handshake rules:
  - start while busy=1 (SHIFT or FINISH) is ignored; there is no queueing.
  - bin_in is don't-care except on the accepting edge.
  - start held high continuously restarts a conversion every IN_WIDTH+2 cycles.
- Output stability:
  - tens, ones and ovf change only on the FINISH edge or on reset. They never show intermediate BCD values, so the downstream display needs no extra latching.
- Width rules:
  - The BCD accumulator is 8 bits. Hundreds overflow is discarded; the saturation flag covers that case.
  - For IN_WIDTH <= 6, sat is always 0.
- Boundary conditions:
  - Input 0 gives 0/0, ovf=0.
  - Input 99 gives 9/9, ovf=0.
  - Input 100 or above gives 9/9, ovf=1.
- Reset mid-conversion: abort, return to IDLE next cycle, all outputs to reset values, and no done pulse.
- reset and start together: reset wins; no conversion starts.

Test Plan:
1. Reset, then start with bin_in=42 → busy high 8 cycles; done pulses 8 clocks after the accepting edge; tens=4, ones=2, ovf=0.
2. Convert bin_in=0, then bin_in=99 → 0/0 then 9/9, ovf=0 both times; outputs held steady between the two done pulses.
3. bin_in=100 and bin_in=127 → tens=9, ones=9, ovf=1; a following conversion of 5 → 0/5 with ovf cleared to 0.
4. Start 37, then pulse start with bin_in=81 at cycle 3 of busy → 81 is ignored; result 3/7; exactly one done pulse.
5. Start 64, assert reset at cycle 4 of busy → busy=0, tens=ones=0, no done pulse; a later start of 64 → 6/4.
6. start held high with bin_in=58 for 30 cycles → done pulses every 9 cycles, each with 5/8; reset and start asserted together → no conversion.
